// File: rtl/rv32_fetch.sv
// rv32_fetch: single-outstanding RV32 instruction fetch stage.
//
// Requests one word at a time from instruction memory. A returned word is
// registered and presented to the decoder with its address one cycle later.
// Redirects from execute take precedence over everything else. A redirect
// to a target that is not word aligned parks the stage in TRAP with
// misaligned set. Only an aligned redirect or reset leaves TRAP.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   stall           decoder cannot accept a new instruction this cycle
//   redirect        redirect request from execute
//   redirect_pc     redirect target, valid with redirect
//   imem_req        memory read request (combinational)
//   imem_addr       address of the current request (internal fetch pc)
//   imem_ack        memory returns imem_rdata this cycle
//   imem_rdata      returned instruction word
//   instruction     registered instruction presented to the decoder
//   pc              address of the presented instruction
//   inst_valid      instruction/pc hold a valid fetched word
//   misaligned      last redirect target was not 4-byte aligned
module rv32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        inst_valid,
  output logic        misaligned
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   fetch_pc_n;
  logic [XLEN-1:0]   instruction_n;
  logic [XLEN-1:0]   pc_n;
  logic              inst_valid_n;
  logic              misaligned_n;

  logic              hold;
  logic              transfer;
  logic              target_aligned;

  // A presented word the decoder is not taking blocks any new request.
  assign hold           = inst_valid && stall;
  assign imem_req       = (state == REQ) && !hold;
  assign transfer       = imem_req && imem_ack;
  assign imem_addr      = fetch_pc;
  assign target_aligned = (redirect_pc[1:0] == 2'b00);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      instruction <= NOP_INSN;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      instruction <= instruction_n;
      pc          <= pc_n;
      inst_valid  <= inst_valid_n;
      misaligned  <= misaligned_n;
    end
  end

  // Next-state and datapath update; redirect overrides transfer and stall.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    instruction_n = instruction;
    pc_n          = pc;
    inst_valid_n  = inst_valid;
    misaligned_n  = misaligned;

    if (redirect) begin
      // Any word returned this cycle belongs to the old stream and is dropped.
      inst_valid_n = 1'b0;
      fetch_pc_n   = redirect_pc;
      if (target_aligned) begin
        state_n      = REQ;
        misaligned_n = 1'b0;
      end else begin
        state_n      = TRAP;
        misaligned_n = 1'b1;
        pc_n         = redirect_pc;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_n = REQ;
        end
        REQ: begin
          if (transfer) begin
            instruction_n = imem_rdata;
            pc_n          = fetch_pc;
            inst_valid_n  = 1'b1;
            fetch_pc_n    = fetch_pc + PC_STEP;
          end else if (!stall) begin
            inst_valid_n  = 1'b0;
          end
        end
        TRAP: begin
          state_n = TRAP;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_fetch.sv
// tb_rv32_fetch: scenario tests for rv32_fetch with a word scoreboard.
module tb_rv32_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        inst_valid;
  logic        misaligned;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t e;

  rv32_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instruction(instruction),
    .pc(pc),
    .inst_valid(inst_valid),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'habcd_e237;
      32'h0000_0004: mem_word = 32'h0040_00ef;
      default:       mem_word = a ^ 32'h5a5a_0000;
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (inst_valid !== 1'b0 || misaligned !== 1'b0 || imem_req !== 1'b0)
      begin bad++; $display("FAIL reset_flags got v=%b mis=%b req=%b want 0 0 0", inst_valid, misaligned, imem_req); end
    total++;
    if (instruction !== NOP_INSN)
      begin bad++; $display("FAIL reset_insn got %h want %h", instruction, NOP_INSN); end
    total++;
    if (pc !== RESET_PC || imem_addr !== RESET_PC)
      begin bad++; $display("FAIL reset_pc got pc=%h addr=%h want %h", pc, imem_addr, RESET_PC); end
  endtask

  task automatic test_first_fetch;
    @(negedge clk); rst = 1'b0; imem_ack = 1'b1; #1;
    total++;
    if (imem_req !== 1'b0)
      begin bad++; $display("FAIL idle_req got %b want 0", imem_req); end
    @(posedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL req_rise got req=%b addr=%h want 1 0", imem_req, imem_addr); end
    sb.push_back({32'h0000_0000, 32'habcd_e237});
    for (int i = 0; i < 2; i++) begin
      if (i == 1) sb.push_back({32'h0000_0004, 32'h0040_00ef});
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
        begin bad++; $display("FAIL first_fetch%0d got v=%b pc=%h ins=%h want 1 %h %h", i, inst_valid, pc, instruction, e.pc, e.ins); end
    end
  endtask

  task automatic test_stall;
    sb.push_back({32'h8, mem_word(32'h8)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL stall_pre got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
    @(negedge clk); stall = 1'b1; #1;
    total++;
    if (imem_req !== 1'b0 || imem_addr !== 32'hc)
      begin bad++; $display("FAIL stall_req got req=%b addr=%h want 0 c", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (inst_valid !== 1'b1 || pc !== 32'h8 || instruction !== mem_word(32'h8) || imem_req !== 1'b0 || imem_addr !== 32'hc)
        begin bad++; $display("FAIL stall_hold%0d got v=%b pc=%h ins=%h req=%b addr=%h want 1 8 %h 0 c", i, inst_valid, pc, instruction, imem_req, imem_addr, mem_word(32'h8)); end
    end
    @(negedge clk); stall = 1'b0; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hc)
      begin bad++; $display("FAIL stall_resume_req got req=%b addr=%h want 1 c", imem_req, imem_addr); end
    sb.push_back({32'hc, mem_word(32'hc)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL stall_resume got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
  endtask

  task automatic test_ack_gap;
    @(negedge clk); imem_ack = 1'b0; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      begin bad++; $display("FAIL gap_req got req=%b addr=%h want 1 10", imem_req, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (inst_valid !== 1'b0 || imem_addr !== 32'h10 || pc !== 32'hc || imem_req !== 1'b1)
        begin bad++; $display("FAIL gap_wait%0d got v=%b addr=%h pc=%h req=%b want 0 10 c 1", i, inst_valid, imem_addr, pc, imem_req); end
    end
    @(negedge clk); imem_ack = 1'b1;
    sb.push_back({32'h10, mem_word(32'h10)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL gap_ack got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
  endtask

  task automatic test_redirect;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h100; #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14)
      begin bad++; $display("FAIL redir_xfer got req=%b addr=%h want 1 14", imem_req, imem_addr); end
    @(posedge clk); #1;
    total++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h100 || misaligned !== 1'b0)
      begin bad++; $display("FAIL redir_drop got v=%b addr=%h mis=%b want 0 100 0", inst_valid, imem_addr, misaligned); end
    @(negedge clk); redirect = 1'b0;
    sb.push_back({32'h100, mem_word(32'h100)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL redir_target got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
  endtask

  task automatic test_misaligned;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1;
    total++;
    if (misaligned !== 1'b1 || pc !== 32'h102 || inst_valid !== 1'b0 || imem_req !== 1'b0)
      begin bad++; $display("FAIL mis_enter got mis=%b pc=%h v=%b req=%b want 1 102 0 0", misaligned, pc, inst_valid, imem_req); end
    @(negedge clk); redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++;
      if (misaligned !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0)
        begin bad++; $display("FAIL mis_hold%0d got mis=%b req=%b v=%b want 1 0 0", i, misaligned, imem_req, inst_valid); end
    end
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'h301;
    @(posedge clk); #1;
    total++;
    if (misaligned !== 1'b1 || pc !== 32'h301 || imem_req !== 1'b0)
      begin bad++; $display("FAIL mis_again got mis=%b pc=%h req=%b want 1 301 0", misaligned, pc, imem_req); end
    @(negedge clk); redirect_pc = 32'h200;
    @(posedge clk); #1;
    total++;
    if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0)
      begin bad++; $display("FAIL mis_exit got mis=%b req=%b addr=%h v=%b want 0 1 200 0", misaligned, imem_req, imem_addr, inst_valid); end
    @(negedge clk); redirect = 1'b0;
    sb.push_back({32'h200, mem_word(32'h200)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL mis_refetch got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
  endtask

  task automatic test_wrap_and_reset;
    @(negedge clk); redirect = 1'b1; redirect_pc = 32'hffff_fffc;
    @(posedge clk); #1;
    @(negedge clk); redirect = 1'b0;
    sb.push_back({32'hffff_fffc, mem_word(32'hffff_fffc)});
    @(posedge clk); #1;
    sb.push_back({32'h0000_0000, 32'habcd_e237});
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL wrap_top got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL wrap_zero got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
    // Reset in the middle of a stalled, valid word with a fetch pending.
    @(negedge clk); stall = 1'b1; rst = 1'b1; #1;
    total++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || pc !== RESET_PC || instruction !== NOP_INSN || imem_addr !== RESET_PC)
      begin bad++; $display("FAIL async_rst got v=%b req=%b pc=%h ins=%h addr=%h want 0 0 %h %h %h", inst_valid, imem_req, pc, instruction, imem_addr, RESET_PC, NOP_INSN, RESET_PC); end
    @(negedge clk); rst = 1'b0; stall = 1'b0; #1;
    total++;
    if (imem_req !== 1'b0)
      begin bad++; $display("FAIL rst_idle got req=%b want 0", imem_req); end
    @(posedge clk); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      begin bad++; $display("FAIL rst_refetch_req got req=%b addr=%h want 1 %h", imem_req, imem_addr, RESET_PC); end
    sb.push_back({RESET_PC, mem_word(RESET_PC)});
    @(posedge clk); #1;
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || pc !== e.pc || instruction !== e.ins)
      begin bad++; $display("FAIL rst_refetch got v=%b pc=%h ins=%h want 1 %h %h", inst_valid, pc, instruction, e.pc, e.ins); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_ack_gap();
    test_redirect();
    test_misaligned();
    test_wrap_and_reset();
    total++;
    if (sb.size() != 0)
      begin bad++; $display("FAIL sb_drain got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
